// File: rtl/cond_branch_unit_pkg.sv
// Shared constants for the conditional branch unit: condition codes and FSM state encoding.
package cond_branch_unit_pkg;

    localparam logic [2:0] COND_EQ     = 3'b000;
    localparam logic [2:0] COND_NE     = 3'b001;
    localparam logic [2:0] COND_LT     = 3'b010;
    localparam logic [2:0] COND_GE     = 3'b011;
    localparam logic [2:0] COND_GT     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_ALWAYS = 3'b110;
    localparam logic [2:0] COND_NEVER  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_HOLD       = 2'd2
    } state_t;

    // ALWAYS and NEVER resolve without looking at the flags.
    function automatic logic cond_needs_flags(input logic [2:0] cond);
        return !((cond == COND_ALWAYS) || (cond == COND_NEVER));
    endfunction

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// Combinational condition table: maps a condition code and {gt,lt,eq} to a taken bit.
module cond_eval
    import cond_branch_unit_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       gt,
    input  logic       lt,
    input  logic       eq,
    output logic       taken
);

    // Flags are used literally; contradictory combinations are not screened.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ:     taken = eq;
            COND_NE:     taken = !eq;
            COND_LT:     taken = lt;
            COND_GE:     taken = !lt;
            COND_GT:     taken = gt;
            COND_LE:     taken = !gt;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// Conditional branch resolver: waits for comparator flags, then holds a redirect until consumed.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
//
// Handshakes: a request transfers on a cycle where br_valid && br_ready; a result transfers
// on a cycle where redir_valid && redir_ready. Held outputs stay stable until that transfer.
module cond_branch_unit
    import cond_branch_unit_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we,
    input  logic            gt_in,
    input  logic            lt_in,
    input  logic            eq_in,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_target,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [PC_W-1:0] redir_pc,
    output logic            redir_taken,
    output logic            flags_valid,
    output state_t          dbg_state
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     taken_cnt,
    output logic [15:0]     ntaken_cnt
`endif
);

    state_t            r_state;
    logic [2:0]        r_flags;
    logic              r_flags_valid;
    logic [2:0]        r_cond;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_target;
    logic [PC_W-1:0]   r_redir_pc;
    logic              r_redir_taken;

    logic [2:0]        w_flags;
    logic [2:0]        w_cond;
    logic [PC_W-1:0]   w_pc;
    logic [PC_W-1:0]   w_target;
    logic              w_taken;
    logic [PC_W-1:0]   w_next_pc;
    logic              w_accept;
    logic              w_flags_avail;
    logic              w_done;

    // Same-cycle flag_we bypasses the register so the freshest flags are evaluated.
    assign w_flags  = flag_we ? {gt_in, lt_in, eq_in} : r_flags;
    assign w_cond   = (r_state == ST_IDLE) ? br_cond   : r_cond;
    assign w_pc     = (r_state == ST_IDLE) ? br_pc     : r_pc;
    assign w_target = (r_state == ST_IDLE) ? br_target : r_target;

    cond_eval u_cond_eval (
        .cond  (w_cond),
        .gt    (w_flags[2]),
        .lt    (w_flags[1]),
        .eq    (w_flags[0]),
        .taken (w_taken)
    );

    assign w_next_pc     = w_taken ? w_target : (w_pc + {{(PC_W-1){1'b0}}, 1'b1});
    assign w_accept      = br_valid && (r_state == ST_IDLE);
    assign w_flags_avail = r_flags_valid || flag_we || !cond_needs_flags(br_cond);
    assign w_done        = (r_state == ST_HOLD) && redir_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags       <= 3'b000;
            r_flags_valid <= 1'b0;
        end else if (flag_we) begin
            r_flags       <= {gt_in, lt_in, eq_in};
            r_flags_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cond        <= 3'b000;
            r_pc          <= '0;
            r_target      <= '0;
            r_redir_pc    <= '0;
            r_redir_taken <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cond   <= br_cond;
                        r_pc     <= br_pc;
                        r_target <= br_target;
                        if (w_flags_avail) begin
                            r_redir_pc    <= w_next_pc;
                            r_redir_taken <= w_taken;
                            r_state       <= ST_HOLD;
                        end else begin
                            r_state <= ST_WAIT_FLAGS;
                        end
                    end
                end
                ST_WAIT_FLAGS: begin
                    if (flag_we) begin
                        r_redir_pc    <= w_next_pc;
                        r_redir_taken <= w_taken;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redir_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_ntaken_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt  <= 16'h0000;
            r_ntaken_cnt <= 16'h0000;
        end else if (w_done) begin
            if (r_redir_taken && (r_taken_cnt != 16'hFFFF)) begin
                r_taken_cnt <= r_taken_cnt + 16'h0001;
            end
            if (!r_redir_taken && (r_ntaken_cnt != 16'hFFFF)) begin
                r_ntaken_cnt <= r_ntaken_cnt + 16'h0001;
            end
        end
    end

    assign taken_cnt  = r_taken_cnt;
    assign ntaken_cnt = r_ntaken_cnt;
`endif

    // rst_n gates br_ready so no request can be taken while reset is held.
    assign br_ready    = rst_n && (r_state == ST_IDLE);
    assign redir_valid = (r_state == ST_HOLD);
    assign redir_pc    = r_redir_pc;
    assign redir_taken = r_redir_taken;
    assign flags_valid = r_flags_valid;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed self-checking bench for cond_branch_unit; also checks the counters when BRANCH_STATS_EN is defined.
module tb_cond_branch_unit;
    import cond_branch_unit_pkg::*;

    localparam int PC_W = 16;

    logic            clk;
    logic            rst_n;
    logic            flag_we;
    logic            gt_in;
    logic            lt_in;
    logic            eq_in;
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] br_target;
    logic            redir_valid;
    logic            redir_ready;
    logic [PC_W-1:0] redir_pc;
    logic            redir_taken;
    logic            flags_valid;
    state_t          dbg_state;
`ifdef BRANCH_STATS_EN
    logic [15:0]     taken_cnt;
    logic [15:0]     ntaken_cnt;
`endif

    int checks_total;
    int checks_passed;

    cond_branch_unit #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flag_we     (flag_we),
        .gt_in       (gt_in),
        .lt_in       (lt_in),
        .eq_in       (eq_in),
        .br_valid    (br_valid),
        .br_ready    (br_ready),
        .br_cond     (br_cond),
        .br_pc       (br_pc),
        .br_target   (br_target),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .redir_taken (redir_taken),
        .flags_valid (flags_valid),
        .dbg_state   (dbg_state)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt   (taken_cnt),
        .ntaken_cnt  (ntaken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_flags(input logic gt, input logic lt, input logic eq);
        flag_we = 1'b1;
        gt_in   = gt;
        lt_in   = lt;
        eq_in   = eq;
    endtask

    task automatic clr_flags();
        flag_we = 1'b0;
        gt_in   = 1'b0;
        lt_in   = 1'b0;
        eq_in   = 1'b0;
    endtask

    task automatic offer(input logic [2:0] cond, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
        br_valid  = 1'b1;
        br_cond   = cond;
        br_pc     = pc;
        br_target = tgt;
    endtask

    task automatic handshake();
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
    endtask

    logic [7:0]      exp_tbl;
    logic            exp_taken;
    logic [PC_W-1:0] exp_pc;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n       = 1'b0;
        br_valid    = 1'b0;
        br_cond     = 3'b000;
        br_pc       = '0;
        br_target   = '0;
        redir_ready = 1'b0;
        clr_flags();

        // Reset state
        #2;
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_br_ready",    32'(br_ready),    32'd0);
        chk("rst_flags_valid", 32'(flags_valid), 32'd0);
        chk("rst_redir_pc",    32'(redir_pc),    32'd0);
        chk("rst_redir_taken", 32'(redir_taken), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_br_ready", 32'(br_ready), 32'd1);

        // EQ taken, one-cycle latency
        set_flags(1'b0, 1'b0, 1'b1);
        tick();
        clr_flags();
        chk("eq_flags_valid", 32'(flags_valid), 32'd1);
        offer(COND_EQ, 16'h0010, 16'h0040);
        tick();
        br_valid = 1'b0;
        chk("eq_valid", 32'(redir_valid), 32'd1);
        chk("eq_taken", 32'(redir_taken), 32'd1);
        chk("eq_pc",    32'(redir_pc),    32'h0040);
        handshake();
        chk("eq_done_valid", 32'(redir_valid), 32'd0);

        // LT waits for flags after reset
        rst_n = 1'b0;
        #1;
        chk("rst2_flags_valid", 32'(flags_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        offer(COND_LT, 16'h0100, 16'h0200);
        tick();
        br_valid = 1'b0;
        chk("lt_wait_state", 32'(dbg_state), 32'(ST_WAIT_FLAGS));
        for (int i = 0; i < 5; i++) begin
            chk("lt_wait_valid", 32'(redir_valid), 32'd0);
            tick();
        end
        set_flags(1'b0, 1'b1, 1'b0);
        tick();
        clr_flags();
        chk("lt_valid", 32'(redir_valid), 32'd1);
        chk("lt_taken", 32'(redir_taken), 32'd1);
        chk("lt_pc",    32'(redir_pc),    32'h0200);
        handshake();

        // LE with same-cycle bypass: stale gt=1, incoming lt=1
        set_flags(1'b1, 1'b0, 1'b0);
        tick();
        offer(COND_LE, 16'hFFFF, 16'h1234);
        set_flags(1'b0, 1'b1, 1'b0);
        tick();
        br_valid = 1'b0;
        clr_flags();
        chk("byp_taken", 32'(redir_taken), 32'd1);
        chk("byp_pc",    32'(redir_pc),    32'h1234);
        handshake();

        // LE not taken, PC wraps
        set_flags(1'b1, 1'b0, 1'b0);
        tick();
        clr_flags();
        offer(COND_LE, 16'hFFFF, 16'h1234);
        tick();
        br_valid = 1'b0;
        chk("wrap_taken", 32'(redir_taken), 32'd0);
        chk("wrap_pc",    32'(redir_pc),    32'h0000);

        // Hold stability under backpressure and a flag write
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_flags(1'b0, 1'b0, 1'b1);
            tick();
            clr_flags();
            chk("hold_valid",    32'(redir_valid), 32'd1);
            chk("hold_pc",       32'(redir_pc),    32'h0000);
            chk("hold_taken",    32'(redir_taken), 32'd0);
            chk("hold_br_ready", 32'(br_ready),    32'd0);
        end
        offer(COND_ALWAYS, 16'h0020, 16'h0300);
        redir_ready = 1'b1;
        chk("hs_br_ready", 32'(br_ready), 32'd0);
        tick();
        redir_ready = 1'b0;
        chk("post_hs_valid",    32'(redir_valid), 32'd0);
        chk("post_hs_br_ready", 32'(br_ready),    32'd1);
        tick();
        br_valid = 1'b0;
        chk("always_taken", 32'(redir_taken), 32'd1);
        chk("always_pc",    32'(redir_pc),    32'h0300);
        handshake();

        // Full condition table with flags {gt,lt,eq} = 010
        exp_tbl = 8'b0110_0110;
        set_flags(1'b0, 1'b1, 1'b0);
        tick();
        clr_flags();
        for (int i = 0; i < 8; i++) begin
            offer(3'(i), 16'h0100 + 16'(i), 16'h0A00 + 16'(i));
            tick();
            br_valid  = 1'b0;
            exp_taken = exp_tbl[i];
            exp_pc    = exp_taken ? (16'h0A00 + 16'(i)) : (16'h0101 + 16'(i));
            chk("tbl_taken", 32'(redir_taken), 32'(exp_taken));
            chk("tbl_pc",    32'(redir_pc),    32'(exp_pc));
            handshake();
        end

        // Reset pulsed during HOLD
        offer(COND_ALWAYS, 16'h0050, 16'h0600);
        tick();
        br_valid = 1'b0;
        chk("pre_rst_valid", 32'(redir_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid",       32'(redir_valid), 32'd0);
        chk("midrst_flags_valid", 32'(flags_valid), 32'd0);
        chk("midrst_pc",          32'(redir_pc),    32'd0);
        chk("midrst_br_ready",    32'(br_ready),    32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Three taken and two not-taken handshakes
        for (int i = 0; i < 5; i++) begin
            offer((i < 3) ? COND_ALWAYS : COND_NEVER, 16'h0700, 16'h0800);
            tick();
            br_valid = 1'b0;
            chk("stat_taken", 32'(redir_taken), (i < 3) ? 32'd1 : 32'd0);
            handshake();
        end
`ifdef BRANCH_STATS_EN
        chk("taken_cnt",  32'(taken_cnt),  32'd3);
        chk("ntaken_cnt", 32'(ntaken_cnt), 32'd2);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/cond_branch_unit.md
COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 Parameter: PC_W, default 16, width of the program counter and branch target.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flag_we  input  1  latch gt_in/lt_in/eq_in into the flags register this cycle.
REQ-005 gt_in, lt_in, eq_in  input  1 each  comparator flags from comp16b.
REQ-006 br_valid  input  1  branch request offered.
REQ-007 br_ready  output  1  unit accepts a request this cycle.
REQ-008 br_cond  input  3  condition code.
REQ-009 br_pc  input  PC_W  address of the branch instruction.
REQ-010 br_target  input  PC_W  taken destination.
REQ-011 redir_valid  output  1  resolved result held.
REQ-012 redir_ready  input  1  consumer accepts the result.
REQ-013 redir_pc  output  PC_W  next fetch address.
REQ-014 redir_taken  output  1  branch taken.
REQ-015 flags_valid  output  1  flags register has been written since reset.

Function
REQ-016 Flags register {gt,lt,eq} SHALL load on flag_we in every state; flags_valid SHALL set on the first flag_we.
REQ-017 Condition table SHALL be: 000 EQ=eq; 001 NE=!eq; 010 LT=lt; 011 GE=!lt; 100 GT=gt; 101 LE=!gt; 110 ALWAYS=1; 111 NEVER=0. Inconsistent flag combinations are evaluated literally with no checking.
REQ-018 FSM states SHALL be IDLE, WAIT_FLAGS and HOLD; br_ready=1 only in IDLE; redir_valid=1 only in HOLD.
REQ-019 IDLE: on br_valid, the unit SHALL capture br_cond, br_pc and br_target. It SHALL go to HOLD if flags are available (flags_valid, same-cycle flag_we, or cond 110/111), else to WAIT_FLAGS.
REQ-020 A flag_we in the same cycle as acceptance SHALL bypass: the new flags are used, not the stale register.
REQ-021 WAIT_FLAGS: on flag_we, the unit SHALL evaluate using the incoming flags and go to HOLD next cycle; otherwise it stays, indefinitely.
REQ-022 The result SHALL be registered on entry to HOLD: redir_taken = condition; redir_pc = taken ? target : br_pc+1, modulo 2^PC_W (all-ones wraps to 0).
REQ-023 Latency: acceptance in cycle N with flags available SHALL give redir_valid=1 in cycle N+1.
REQ-024 HOLD: redir_pc and redir_taken SHALL stay stable until redir_ready; on redir_ready the unit SHALL return to IDLE, so the next acceptance is no earlier than the following cycle.
REQ-025 A flag_we during HOLD SHALL update the flags register and SHALL NOT alter the held result.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, flags register 000, flags_valid 0, redir_valid 0, redir_taken 0, redir_pc 0.
REQ-027 While rst_n is low, br_ready SHALL be 0. Reset mid-WAIT_FLAGS or mid-HOLD SHALL discard the pending request without emitting it.
REQ-028 Deassertion of rst_n SHALL take effect at the next rising edge of clk.

Configuration
REQ-029 With BRANCH_STATS_EN defined, the unit SHALL add outputs taken_cnt[15:0] and ntaken_cnt[15:0]:
- each counter increments on a HOLD handshake according to redir_taken;
- both saturate at 16'hFFFF;
- both reset to 0.
REQ-030 Without BRANCH_STATS_EN, the counters and their ports SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-031 A shared package SHALL hold the condition-code constants (COND_EQ..COND_NEVER) and the FSM state encoding.
REQ-032 The condition table SHALL be a combinational sub-module cond_eval (inputs cond, gt, lt, eq; output taken), instantiated once.

Verification
REQ-033 flag_we with eq=1; next cycle br_cond=000, br_pc=16'h0010, br_target=16'h0040 -> redir_valid one cycle later, redir_taken=1, redir_pc=16'h0040.
REQ-034 After reset, br_cond=010 with no flags -> WAIT_FLAGS, redir_valid stays 0 for 5 cycles; flag_we with lt=1 -> next cycle redir_pc=target, redir_taken=1.
REQ-035 Flags gt=1 latched; br_cond=101, br_pc=16'hFFFF, with a same-cycle flag_we of lt=1 -> bypass gives taken=1, redir_pc=target.
REQ-036 br_cond=101, br_pc=16'hFFFF, flags gt=1, no bypass -> redir_taken=0, redir_pc=16'h0000.
REQ-037 HOLD with redir_ready low for 3 cycles plus a flag_we -> outputs stable; br_ready stays 0 until the cycle after the handshake.
REQ-038 rst_n pulsed low during HOLD -> redir_valid=0 immediately and flags_valid=0. With BRANCH_STATS_EN, after 3 taken and 2 not-taken handshakes -> taken_cnt=3, ntaken_cnt=2.
